// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited memory requester, in-order response queue and IF/ID register.
// A redirect flushes the queue and drains stale in-flight responses before fetching from the new target.
module fetch_queue #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 4  // 2, 4 or 8: also the in-flight credit limit
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        ifIdWrite,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGrant,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  output logic [31:0] programCounterOut,
  output logic [31:0] instruction,
  output logic        ifIdValid
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned PTR_W  = $clog2(QUEUE_DEPTH);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]       ifid_instr_q, ifid_instr_d;
  logic              ifid_valid_q, ifid_valid_d;

  entry_t            entries_q [QUEUE_DEPTH];
  entry_t            head_entry;
  entry_t            push_entry;
  logic              grant_fire;
  logic              resp_fire;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] target_aligned;
  logic [SUM_W-1:0]  credit_used;

  assign grant_fire     = imemGrant && req_q;
  assign resp_fire      = imemRespValid && (out_q != '0);
  assign target_aligned = redirectTarget & 32'hFFFF_FFFC;
  assign head_entry     = entries_q[head_q];

  // In FETCH every outstanding request is contiguous and ends at pc_q - 4, so the oldest
  // one (the one now responding) sits at pc_q - 4*out_q; its IF/ID pc is that plus 4.
  assign resp_pc = pc_q - (ADDR_W'(out_q) << 2) + ADDR_W'(4);

  // State register
  always_ff @(posedge clk or negedge resetN) begin : state_reg
    if (!resetN) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: any redirect or an ongoing flush waits for the in-flight count to drain
  always_comb begin : next_state
    state_d = state_q;
    if (redirectValid || (state_q == ST_FLUSH)) begin
      state_d = (out_d == '0) ? ST_FETCH : ST_FLUSH;
    end
  end

  // Credit accounting, fetch PC, queue pointers and IF/ID next values
  always_comb begin : datapath_next
    out_d        = out_q + CNT_W'(grant_fire) - CNT_W'(resp_fire);
    pc_d         = pc_q;
    push         = resp_fire && (state_q == ST_FETCH) && !redirectValid;
    pop          = !redirectValid && ifIdWrite && (cnt_q != '0);
    cnt_d        = cnt_q;
    head_d       = head_q;
    tail_d       = tail_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    push_entry.pc    = resp_pc;
    push_entry.instr = imemRespData;

    if (redirectValid) begin
      pc_d = target_aligned;
    end else if (grant_fire) begin
      pc_d = pc_q + ADDR_W'(4);
    end

    if (redirectValid) begin
      cnt_d        = '0;
      head_d       = '0;
      tail_d       = '0;
      ifid_pc_d    = '0;
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
    end else begin
      cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
      head_d = head_q + PTR_W'(pop);
      tail_d = tail_q + PTR_W'(push);
      if (ifIdWrite) begin
        if (cnt_q != '0) begin
          ifid_pc_d    = head_entry.pc;
          ifid_instr_d = head_entry.instr;
          ifid_valid_d = 1'b1;
        end else begin
          ifid_pc_d    = '0;
          ifid_instr_d = '0;
          ifid_valid_d = 1'b0;
        end
      end
    end
  end

  // Request outputs are registered from next state: held until granted by construction
  always_comb begin : output_next
    credit_used = SUM_W'(out_d) + SUM_W'(cnt_d);
    req_d       = (state_d == ST_FETCH) && (credit_used < SUM_W'(QUEUE_DEPTH));
    addr_d      = pc_d;
  end

  always_ff @(posedge clk or negedge resetN) begin : ctrl_regs
    if (!resetN) begin
      pc_q         <= RESET_PC;
      out_q        <= '0;
      cnt_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      out_q        <= out_d;
      cnt_q        <= cnt_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Queue payload storage; validity is tracked only by the pointers and count
  always_ff @(posedge clk) begin : queue_store
    if (push) begin
      entries_q[tail_q] <= push_entry;
    end
  end

  assign imemReq           = req_q;
  assign imemAddr          = addr_q;
  assign programCounterOut = ifid_pc_q;
  assign instruction       = ifid_instr_q;
  assign ifIdValid         = ifid_valid_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a behavioural instruction memory returns ~address after a
// programmable latency; each task checks IF/ID and request outputs at negedges.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        ifIdWrite = 1'b0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectTarget = '0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGrant = 1'b0;
  logic        imemRespValid = 1'b0;
  logic [31:0] imemRespData = '0;
  logic [31:0] programCounterOut;
  logic [31:0] instruction;
  logic        ifIdValid;

  int unsigned lat = 1;
  logic        grant_en = 1'b0;
  logic        spurious = 1'b0;
  int unsigned cyc = 0;
  int unsigned grant_cnt = 0;
  logic [31:0] pend_addr [$];
  int unsigned pend_due [$];

  int          n_checks = 0;
  int          n_fail = 0;
  logic [64:0] ifid;
  logic [32:0] req_bus;
  logic [64:0] exp_ifid;
  logic [32:0] exp_req;

  assign ifid    = {ifIdValid, programCounterOut, instruction};
  assign req_bus = {imemReq, imemAddr};

  fetch_queue dut (
    .clk               (clk),
    .resetN            (resetN),
    .ifIdWrite         (ifIdWrite),
    .redirectValid     (redirectValid),
    .redirectTarget    (redirectTarget),
    .imemReq           (imemReq),
    .imemAddr          (imemAddr),
    .imemGrant         (imemGrant),
    .imemRespValid     (imemRespValid),
    .imemRespData      (imemRespData),
    .programCounterOut (programCounterOut),
    .instruction       (instruction),
    .ifIdValid         (ifIdValid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: grant decided 1 time unit after negedge, response due lat edges after the grant edge
  always begin : mem_model
    @(negedge clk);
    #1;
    if (!resetN) begin
      pend_addr.delete();
      pend_due.delete();
      imemGrant     = 1'b0;
      imemRespValid = 1'b0;
      imemRespData  = '0;
    end else begin
      imemGrant = grant_en && imemReq;
      if (imemGrant) begin
        pend_addr.push_back(imemAddr);
        pend_due.push_back(cyc + 1 + lat);
        grant_cnt++;
      end
      if (pend_due.size() != 0 && pend_due[0] == cyc + 1) begin
        imemRespValid = 1'b1;
        imemRespData  = ~pend_addr[0];
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else if (spurious) begin
        imemRespValid = 1'b1;
        imemRespData  = 32'hBAD0_BAD0;
      end else begin
        imemRespValid = 1'b0;
        imemRespData  = '0;
      end
    end
  end

  task automatic do_reset(input int unsigned l, input logic g, input logic w);
    resetN         = 1'b0;
    redirectValid  = 1'b0;
    redirectTarget = '0;
    spurious       = 1'b0;
    lat            = l;
    grant_en       = g;
    ifIdWrite      = w;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    lat = 1; grant_en = 1'b1; ifIdWrite = 1'b1;
    #2 resetN = 1'b0;
    @(negedge clk);
    exp_req = {1'b0, 32'h0};
    n_checks++; if (req_bus !== exp_req) begin n_fail++; $display("FAIL reset_req: got %h expected %h", req_bus, exp_req); end
    exp_ifid = '0;
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL reset_ifid: got %h expected %h", ifid, exp_ifid); end
    resetN = 1'b1;
    #1;
    n_checks++; if (imemReq !== 1'b0) begin n_fail++; $display("FAIL release_req_low: got %b expected 0", imemReq); end
    @(negedge clk);
    exp_req = {1'b1, 32'h0};
    n_checks++; if (req_bus !== exp_req) begin n_fail++; $display("FAIL first_req: got %h expected %h", req_bus, exp_req); end
  endtask

  task automatic test_basic_stream();
    do_reset(1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    exp_ifid = '0;
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL stream_no_bypass: got %h expected %h", ifid, exp_ifid); end
    @(negedge clk);
    exp_ifid = {1'b1, 32'h4, 32'hFFFF_FFFF};
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL stream_ifid0: got %h expected %h", ifid, exp_ifid); end
    @(negedge clk);
    exp_ifid = {1'b1, 32'h8, 32'hFFFF_FFFB};
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL stream_ifid1: got %h expected %h", ifid, exp_ifid); end
    @(negedge clk);
    exp_ifid = {1'b1, 32'hC, 32'hFFFF_FFF7};
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL stream_ifid2: got %h expected %h", ifid, exp_ifid); end
  endtask

  task automatic test_stall_drain();
    int unsigned g0;
    do_reset(1, 1'b1, 1'b0);
    g0 = grant_cnt;
    repeat (10) @(negedge clk);
    n_checks++; if (grant_cnt - g0 != 4) begin n_fail++; $display("FAIL stall_grants: got %0d expected 4", grant_cnt - g0); end
    exp_req = {1'b0, 32'h10};
    n_checks++; if (req_bus !== exp_req) begin n_fail++; $display("FAIL stall_req: got %h expected %h", req_bus, exp_req); end
    exp_ifid = '0;
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL stall_ifid_hold: got %h expected %h", ifid, exp_ifid); end
    ifIdWrite = 1'b1;
    @(negedge clk);
    exp_ifid = {1'b1, 32'h4, 32'hFFFF_FFFF};
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL drain0: got %h expected %h", ifid, exp_ifid); end
    exp_req = {1'b1, 32'h10};
    n_checks++; if (req_bus !== exp_req) begin n_fail++; $display("FAIL drain_credit: got %h expected %h", req_bus, exp_req); end
    @(negedge clk);
    exp_ifid = {1'b1, 32'h8, 32'hFFFF_FFFB};
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL drain1: got %h expected %h", ifid, exp_ifid); end
    @(negedge clk);
    exp_ifid = {1'b1, 32'hC, 32'hFFFF_FFF7};
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL drain2: got %h expected %h", ifid, exp_ifid); end
    @(negedge clk);
    exp_ifid = {1'b1, 32'h10, 32'hFFFF_FFF3};
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL drain3: got %h expected %h", ifid, exp_ifid); end
  endtask

  task automatic test_redirect_flush();
    do_reset(3, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    exp_req = {1'b1, 32'hC};
    n_checks++; if (req_bus !== exp_req) begin n_fail++; $display("FAIL flush_pre_req: got %h expected %h", req_bus, exp_req); end
    grant_en = 1'b0; redirectValid = 1'b1; redirectTarget = 32'h0000_0103;
    @(negedge clk);
    n_checks++; if (imemReq !== 1'b0) begin n_fail++; $display("FAIL flush_req0: got %b expected 0", imemReq); end
    grant_en = 1'b1; redirectTarget = 32'h0000_0180;
    @(negedge clk);
    redirectValid = 1'b0;
    n_checks++; if (imemReq !== 1'b0) begin n_fail++; $display("FAIL flush_req1: got %b expected 0", imemReq); end
    n_checks++; if (ifIdValid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", ifIdValid); end
    @(negedge clk);
    exp_req = {1'b1, 32'h180};
    n_checks++; if (req_bus !== exp_req) begin n_fail++; $display("FAIL flush_refetch: got %h expected %h", req_bus, exp_req); end
    repeat (4) @(negedge clk);
    n_checks++; if (ifIdValid !== 1'b0) begin n_fail++; $display("FAIL flush_wait_valid: got %b expected 0", ifIdValid); end
    @(negedge clk);
    exp_ifid = {1'b1, 32'h184, 32'hFFFF_FE7F};
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL flush_first: got %h expected %h", ifid, exp_ifid); end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset(1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    exp_req = {1'b1, 32'h4};
    n_checks++; if (req_bus !== exp_req) begin n_fail++; $display("FAIL same_pre_req: got %h expected %h", req_bus, exp_req); end
    grant_en = 1'b0; redirectValid = 1'b1; redirectTarget = 32'h0000_0200;
    @(negedge clk);
    redirectValid = 1'b0; grant_en = 1'b1;
    exp_req = {1'b1, 32'h200};
    n_checks++; if (req_bus !== exp_req) begin n_fail++; $display("FAIL same_req: got %h expected %h", req_bus, exp_req); end
    repeat (2) @(negedge clk);
    exp_ifid = '0;
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL same_bubble: got %h expected %h", ifid, exp_ifid); end
    @(negedge clk);
    exp_ifid = {1'b1, 32'h204, 32'hFFFF_FDFF};
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL same_first: got %h expected %h", ifid, exp_ifid); end
  endtask

  task automatic test_pc_wrap();
    do_reset(1, 1'b0, 1'b1);
    @(negedge clk);
    redirectValid = 1'b1; redirectTarget = 32'hFFFF_FFFC;
    @(negedge clk);
    redirectValid = 1'b0; grant_en = 1'b1;
    exp_req = {1'b1, 32'hFFFF_FFFC};
    n_checks++; if (req_bus !== exp_req) begin n_fail++; $display("FAIL wrap_top: got %h expected %h", req_bus, exp_req); end
    @(negedge clk);
    exp_req = {1'b1, 32'h0};
    n_checks++; if (req_bus !== exp_req) begin n_fail++; $display("FAIL wrap_addr: got %h expected %h", req_bus, exp_req); end
    repeat (2) @(negedge clk);
    exp_ifid = {1'b1, 32'h0, 32'h0000_0003};
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL wrap_ifid: got %h expected %h", ifid, exp_ifid); end
    @(negedge clk);
    exp_ifid = {1'b1, 32'h4, 32'hFFFF_FFFF};
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL wrap_next: got %h expected %h", ifid, exp_ifid); end
  endtask

  task automatic test_spurious_response();
    do_reset(1, 1'b0, 1'b1);
    @(negedge clk);
    spurious = 1'b1;
    repeat (2) @(negedge clk);
    spurious = 1'b0; grant_en = 1'b1;
    exp_req = {1'b1, 32'h0};
    n_checks++; if (req_bus !== exp_req) begin n_fail++; $display("FAIL spur_req: got %h expected %h", req_bus, exp_req); end
    exp_ifid = '0;
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL spur_bubble: got %h expected %h", ifid, exp_ifid); end
    repeat (3) @(negedge clk);
    exp_ifid = {1'b1, 32'h4, 32'hFFFF_FFFF};
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL spur_first: got %h expected %h", ifid, exp_ifid); end
  endtask

  task automatic test_async_reset();
    do_reset(1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    ifIdWrite = 1'b0;
    repeat (4) @(negedge clk);
    exp_req = {1'b0, 32'h14};
    n_checks++; if (req_bus !== exp_req) begin n_fail++; $display("FAIL full_req: got %h expected %h", req_bus, exp_req); end
    exp_ifid = {1'b1, 32'h4, 32'hFFFF_FFFF};
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL full_ifid_hold: got %h expected %h", ifid, exp_ifid); end
    #2 resetN = 1'b0;
    #1;
    exp_req = {1'b0, 32'h0};
    n_checks++; if (req_bus !== exp_req) begin n_fail++; $display("FAIL async_req: got %h expected %h", req_bus, exp_req); end
    exp_ifid = '0;
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL async_ifid: got %h expected %h", ifid, exp_ifid); end
    repeat (2) @(negedge clk);
    ifIdWrite = 1'b1;
    resetN = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (ifIdValid !== 1'b0) begin n_fail++; $display("FAIL post_reset_empty: got %b expected 0", ifIdValid); end
    @(negedge clk);
    exp_ifid = {1'b1, 32'h4, 32'hFFFF_FFFF};
    n_checks++; if (ifid !== exp_ifid) begin n_fail++; $display("FAIL post_reset_first: got %h expected %h", ifid, exp_ifid); end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_stall_drain();
    test_redirect_flush();
    test_redirect_same_cycle();
    test_pc_wrap();
    test_spurious_response();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter QUEUE_DEPTH, 4, instruction queue entries and max in-flight credit; legal values 2, 4, 8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetN  input  1  asynchronous, active-low reset.
REQ-005 ifIdWrite  input  1  1 = IF/ID register may load; 0 = hold (decode stall).
REQ-006 redirectValid  input  1  flush and refetch from redirectTarget.
REQ-007 redirectTarget  input  32  new fetch address; bits [1:0] ignored, treated as 0.
REQ-008 imemReq  output  1  instruction memory request.
REQ-009 imemAddr  output  32  request address, word aligned.
REQ-010 imemGrant  input  1  memory accepted current request this cycle.
REQ-011 imemRespValid  input  1  read data returned, in request order.
REQ-012 imemRespData  input  32  instruction word.
REQ-013 programCounterOut  output  32  IF/ID: address of instruction plus 4.
REQ-014 instruction  output  32  IF/ID: instruction word; 32'h0000_0000 when bubble.
REQ-015 ifIdValid  output  1  IF/ID holds a real instruction.

Function
REQ-016 Fetch PC, outstanding counter (0..QUEUE_DEPTH), queue count (0..QUEUE_DEPTH) and FSM {FETCH, FLUSH} SHALL be the only control state.
REQ-017 In FETCH, imemReq SHALL be 1 iff outstanding + queue count < QUEUE_DEPTH; imemAddr SHALL equal fetch PC.
REQ-018 imemReq and imemAddr SHALL stay stable until imemGrant, except on a redirect edge.
REQ-019 On imemGrant with imemReq=1: outstanding +1, fetch PC +4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-020 On imemRespValid: outstanding -1; in FETCH, store {address+4, data} at queue tail; simultaneous grant and response SHALL net outstanding to unchanged.
REQ-021 imemRespValid with outstanding = 0 SHALL be ignored (no count change, no write).
REQ-022 Queue SHALL never overflow; credit rule of REQ-017 guarantees space for every in-flight response.
REQ-023 Response written at edge N SHALL be loadable into IF/ID at edge N+1 at the earliest (no bypass).
REQ-024 ifIdWrite=1, queue non-empty: IF/ID loads head entry, ifIdValid=1, head pops; same-cycle push and pop SHALL both take effect.
REQ-025 ifIdWrite=1, queue empty: IF/ID loads bubble (instruction 0, programCounterOut 0, ifIdValid 0).
REQ-026 ifIdWrite=0: IF/ID and queue head SHALL hold.
REQ-027 redirectValid SHALL take priority over ifIdWrite and all other events: queue count cleared, IF/ID loaded with bubble, fetch PC := redirectTarget.
REQ-028 A grant or response in the redirect cycle SHALL update outstanding normally; that response SHALL be discarded.
REQ-029 After redirect: if resulting outstanding = 0, state FETCH; else state FLUSH.
REQ-030 In FLUSH: imemReq=0; every response discarded, outstanding -1; when outstanding reaches 0, return to FETCH on next edge.
REQ-031 Redirect while in FLUSH SHALL overwrite fetch PC with the new target and remain in FLUSH.
REQ-032 Queue entries SHALL leave in the order responses arrived.

Reset
REQ-033 resetN=0 SHALL immediately force: state FETCH, fetch PC=RESET_PC, outstanding 0, queue count 0, imemReq 0, imemAddr RESET_PC, instruction 0, programCounterOut 0, ifIdValid 0.
REQ-034 Reset mid-operation SHALL discard all queue contents and in-flight accounting; responses for pre-reset requests are the memory's responsibility to cancel.
REQ-035 First request SHALL be asserted on the first clock edge after resetN rises (imemReq=1 in the following cycle).

Verification
REQ-036 Reset release, grant every cycle, 1-cycle response latency, ifIdWrite=1 -> ifIdValid rises; IF/ID shows instructions from 0x0,0x4,0x8 in order with programCounterOut 0x4,0x8,0xC.
REQ-037 ifIdWrite=0 held 10 cycles, memory always granting -> exactly QUEUE_DEPTH (4) grants, then imemReq=0; IF/ID unchanged; release -> 4 queued words drain in order.
REQ-038 Redirect to 0x100 with 3 outstanding, 3-cycle response latency -> state FLUSH, imemReq=0, 3 responses dropped, next request addr 0x100, ifIdValid 0 until its data arrives.
REQ-039 Redirect and response same cycle, outstanding 1 -> response dropped, outstanding 0, state stays FETCH, imemAddr=target next cycle.
REQ-040 Fetch PC 0xFFFF_FFFC granted -> next imemAddr 0x0000_0000; programCounterOut for that word 0x0000_0000.
REQ-041 resetN pulsed low mid-stream with queue full -> outputs at reset values asynchronously, before next clock edge.
